mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares the single data-memory port between instruction fetch (IF) and load/store (DM) requesters.
// Holds at most one outstanding transaction. Selection is fixed-priority DM-over-IF, with a
// starvation guard for IF. Sequences each transfer through ISSUE/WAIT states and ends it with a
// response timeout. Sits between the fetch/load-store control path and the memory macro.
// PARAMETERS
// MAX_DATA_STREAK  4   consecutive DM grants (while IF pending) before IF is forced to win once
// TIMEOUT          16  cycles in WAIT without mem_rvalid before an error response is returned
// PORTS
// clk        in   1   clock, all state updates on rising edge
// resetn     in   1   synchronous reset, active-low
// if_req     in   1   fetch request; held with if_addr until if_gnt
// if_addr    in   32  fetch address (read only)
// if_gnt     out  1   fetch request accepted by memory (1-cycle pulse)
// if_rvalid  out  1   fetch response valid (1-cycle pulse)
// if_rdata   out  32  fetch read data, valid with if_rvalid
// if_err     out  1   fetch response is a timeout error, valid with if_rvalid
// dm_req     in   1   load/store request; held with payload until dm_gnt
// dm_we      in   1   1 = store, 0 = load
// dm_addr    in   32  load/store address
// dm_wdata   in   32  store data
// dm_be      in   4   store byte enables
// dm_gnt     out  1   load/store request accepted (1-cycle pulse)
// dm_rvalid  out  1   load/store response valid (1-cycle pulse, also for stores)
// dm_rdata   out  32  load data, valid with dm_rvalid
// dm_err     out  1   load/store timeout error, valid with dm_rvalid
// mem_req    out  1   memory request
// mem_we     out  1   memory write enable
// mem_addr   out  32  memory address
// mem_wdata  out  32  memory write data
// mem_be     out  4   memory byte enables (4'hF on reads)
// mem_gnt    in   1   memory accepts request this cycle
// mem_rvalid in   1   memory response this cycle (reads and writes)
// mem_rdata  in   32  memory read data
// BEHAVIOUR
// - Reset (resetn=0 at edge): state=IDLE, owner=DM, streak=0, timer=0.
//   All registered outputs cleared: mem_*, *_rvalid, *_rdata, *_err.
//   Valid mid-transaction; a late mem_rvalid afterwards is ignored.
// - IDLE: when any req is high, select the owner and register its payload into mem_*.
//   Go to ISSUE. mem_req=1 from the next cycle (one cycle of request latency).
//   Selection: DM wins unless (if_req && streak==MAX_DATA_STREAK).
//   If only one requester is high, it wins.
// - streak: +1 on a DM grant decision while if_req=1. Cleared on an IF selection.
//   Cleared on a DM selection with if_req=0. Saturates at MAX_DATA_STREAK.
// - ISSUE: mem_req=1, mem_* stable until mem_gnt.
//   owner_gnt = (state==ISSUE) & mem_gnt & owner (combinational).
//   On mem_gnt: mem_req drops next cycle, timer=0, go to WAIT.
//   If mem_gnt and mem_rvalid occur in the same cycle: complete as below and go to IDLE, skipping WAIT.
// - WAIT: timer increments each cycle.
//   On mem_rvalid: owner_rvalid=1 next cycle, owner_rdata=mem_rdata (0 for stores), owner_err=0.
//   Then go to IDLE.
//   If timer reaches TIMEOUT-1 without mem_rvalid: owner_rvalid=1, owner_err=1, owner_rdata=0.
//   Then go to IDLE.
//   If mem_rvalid arrives in the same cycle as the timeout, it wins (err=0).
// - mem_rvalid seen in IDLE or ISSUE (without gnt) is ignored.
// - Response latency: mem_rvalid at cycle T -> owner_rvalid at T+1.
//   The next arbitration happens at the earliest at T+1, so there is 1 IDLE cycle between transactions.
// - *_rdata holds its last value outside rvalid. Only the owner's response signals ever pulse.
// - No ISSUE timeout: the memory must eventually assert mem_gnt.
// TESTING
// - Reset, then if_req only, addr 0x100, mem_gnt in 1st ISSUE cycle, rvalid 2 cycles later,
//   rdata 0xDEADBEEF -> if_gnt 1 pulse, if_rvalid 1 cycle after mem_rvalid, if_rdata=0xDEADBEEF, if_err=0.
// - dm_req store (addr 0x200, wdata 0x12345678, be 4'b0011) with if_req held high the same cycle
//   -> DM served first with mem_we=1, mem_be=4'b0011; IF served next.
// - dm_req and if_req both held high for 10 transactions (MAX_DATA_STREAK=4)
//   -> grant order DM,DM,DM,DM,IF,DM,DM,DM,DM,IF.
// - Load, mem_rvalid never asserted (TIMEOUT=16)
//   -> dm_rvalid=1, dm_err=1, dm_rdata=0 exactly 16 cycles after the WAIT entry.
//   A mem_rvalid 3 cycles later is ignored.
// - mem_gnt and mem_rvalid in the same cycle (rdata 0xA5A5A5A5)
//   -> dm_gnt and the next-cycle dm_rvalid with 0xA5A5A5A5; state returns to IDLE.
// - resetn=0 for 1 cycle while in WAIT
//   -> all outputs 0, IDLE next cycle; the stale mem_rvalid produces no *_rvalid.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of all requester-side and memory-side signals around mem_port_arbiter.
//   master : the arbiter (drives grants/responses to IF and DM, drives mem_* request)
//   slave  : the environment (fetch unit, load/store unit and memory macro)
// Fetch side : if_req, if_addr -> if_gnt, if_rvalid, if_rdata, if_err
// DM side    : dm_req, dm_we, dm_addr, dm_wdata, dm_be -> dm_gnt, dm_rvalid, dm_rdata, dm_err
// Memory side: mem_req, mem_we, mem_addr, mem_wdata, mem_be -> mem_gnt, mem_rvalid, mem_rdata
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        dm_err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_gnt, dm_rvalid, dm_rdata, dm_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_gnt, dm_rvalid, dm_rdata, dm_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between instruction fetch (IF) and load/store (DM).
// One outstanding transaction at a time; DM has fixed priority, but after MAX_DATA_STREAK
// consecutive DM wins while IF was waiting, IF is forced to win once. A transfer goes
// IDLE -> ISSUE (mem_req held until mem_gnt) -> WAIT (until mem_rvalid or TIMEOUT cycles).
// Ports:
//   clk    : clock, rising edge
//   resetn : synchronous active-low reset
//   bus    : mem_port_arbiter_if.master (IF/DM requester handshakes and memory port)
module mem_port_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4,
    parameter int unsigned TIMEOUT         = 16
) (
    input  logic               clk,
    input  logic               resetn,
    mem_port_arbiter_if.master bus
);
    localparam int unsigned StreakW = $clog2(MAX_DATA_STREAK + 1);
    localparam int unsigned TimerW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DATA_STREAK);
    localparam logic [TimerW-1:0]  TimerLast = TimerW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e             state_q, state_d;
    logic               owner_dm_q, owner_dm_d;
    logic [StreakW-1:0] streak_q, streak_d;
    logic [TimerW-1:0]  timer_q, timer_d;

    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;

    logic        if_rvalid_q, if_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_err_q, if_err_d;
    logic        dm_rvalid_q, dm_rvalid_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        dm_err_q, dm_err_d;

    logic        sel_dm;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    always_comb begin
        state_d     = state_q;
        owner_dm_d  = owner_dm_q;
        streak_d    = streak_q;
        timer_d     = timer_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_err_d    = if_err_q;
        dm_rvalid_d = 1'b0;
        dm_rdata_d  = dm_rdata_q;
        dm_err_d    = dm_err_q;
        sel_dm      = 1'b0;
        resp_valid  = 1'b0;
        resp_err    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.if_req || bus.dm_req) begin
                    sel_dm     = bus.dm_req && !(bus.if_req && streak_q == StreakMax);
                    owner_dm_d = sel_dm;
                    mem_req_d  = 1'b1;
                    state_d    = StIssue;
                    if (sel_dm) begin
                        mem_we_d    = bus.dm_we;
                        mem_addr_d  = bus.dm_addr;
                        mem_wdata_d = bus.dm_wdata;
                        mem_be_d    = bus.dm_we ? bus.dm_be : 4'hF;
                        // The streak only counts DM wins that made IF wait.
                        if (bus.if_req) begin
                            streak_d = (streak_q == StreakMax) ? streak_q
                                                               : streak_q + StreakW'(1);
                        end else begin
                            streak_d = '0;
                        end
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = 4'hF;
                        streak_d    = '0;
                    end
                end
            end
            StIssue: begin
                if (bus.mem_gnt) begin
                    mem_req_d = 1'b0;
                    timer_d   = '0;
                    // A response in the grant cycle completes without visiting WAIT.
                    if (bus.mem_rvalid) begin
                        resp_valid = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                timer_d = timer_q + TimerW'(1);
                // A real response beats a coincident timeout.
                if (bus.mem_rvalid) begin
                    resp_valid = 1'b1;
                    state_d    = StIdle;
                end else if (timer_q == TimerLast) begin
                    resp_valid = 1'b1;
                    resp_err   = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        resp_rdata = (resp_err || mem_we_q) ? 32'h0 : bus.mem_rdata;

        if (resp_valid) begin
            if (owner_dm_q) begin
                dm_rvalid_d = 1'b1;
                dm_rdata_d  = resp_rdata;
                dm_err_d    = resp_err;
            end else begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = resp_rdata;
                if_err_d    = resp_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            owner_dm_q  <= 1'b1;
            streak_q    <= '0;
            timer_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            if_err_q    <= 1'b0;
            dm_rvalid_q <= 1'b0;
            dm_rdata_q  <= '0;
            dm_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_dm_q  <= owner_dm_d;
            streak_q    <= streak_d;
            timer_q     <= timer_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            dm_rvalid_q <= dm_rvalid_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_err_q    <= dm_err_d;
        end
    end

    // Grants are combinational so the requester sees acceptance in the mem_gnt cycle.
    assign bus.if_gnt    = (state_q == StIssue) && bus.mem_gnt && !owner_dm_q;
    assign bus.dm_gnt    = (state_q == StIssue) && bus.mem_gnt && owner_dm_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_err    = if_err_q;
    assign bus.dm_rvalid = dm_rvalid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_err    = dm_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run, all
// checked against a transaction-level reference model (pending requests, DM-win streak,
// expected response per transaction).
module tb_mem_port_arbiter;
    localparam int MaxDataStreak = 4;
    localparam int Timeout       = 16;

    logic clk = 1'b0;
    logic resetn;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MAX_DATA_STREAK(MaxDataStreak),
        .TIMEOUT        (Timeout)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    bit          m_if_pend;
    bit          m_dm_pend;
    logic [31:0] m_if_addr;
    logic        m_dm_we;
    logic [31:0] m_dm_addr;
    logic [31:0] m_dm_wdata;
    logic [3:0]  m_dm_be;
    int          m_streak;
    bit          obs_log[$];   // observed grant owner per transaction, 1 = DM

    task automatic do_reset();
        resetn         = 1'b0;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.dm_req     = 1'b0;
        bus.dm_we      = 1'b0;
        bus.dm_addr    = '0;
        bus.dm_wdata   = '0;
        bus.dm_be      = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        m_if_pend      = 1'b0;
        m_dm_pend      = 1'b0;
        m_streak       = 0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic raise_if(input logic [31:0] addr);
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        m_if_pend   = 1'b1;
        m_if_addr   = addr;
    endtask

    task automatic raise_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be);
        bus.dm_req   = 1'b1;
        bus.dm_we    = we;
        bus.dm_addr  = addr;
        bus.dm_wdata = wdata;
        bus.dm_be    = be;
        m_dm_pend    = 1'b1;
        m_dm_we      = we;
        m_dm_addr    = addr;
        m_dm_wdata   = wdata;
        m_dm_be      = be;
    endtask

    // Plays the memory for one transaction. Called in an IDLE cycle (negedge) with the
    // requests already set. mode: 0 = rvalid rdly cycles into WAIT, 1 = rvalid with gnt,
    // 2 = never respond (timeout). Returns at the negedge where the response is visible.
    task automatic run_txn(input int gnt_dly, input int mode, input int rdly,
                           input logic [31:0] rdata);
        bit          exp_dm;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          resp_k;

        exp_dm = m_dm_pend && !(m_if_pend && m_streak == MaxDataStreak);
        if (exp_dm) begin
            exp_we    = m_dm_we;
            exp_addr  = m_dm_addr;
            exp_wdata = m_dm_wdata;
            exp_be    = m_dm_we ? m_dm_be : 4'hF;
            m_streak  = m_if_pend ? ((m_streak < MaxDataStreak) ? m_streak + 1 : m_streak) : 0;
        end else begin
            exp_we    = 1'b0;
            exp_addr  = m_if_addr;
            exp_wdata = '0;
            exp_be    = 4'hF;
            m_streak  = 0;
        end
        exp_err   = (mode == 2);
        exp_rdata = (exp_err || exp_we) ? 32'h0 : rdata;
        resp_k    = (mode == 1) ? 0 : (mode == 2) ? Timeout : rdly + 1;

        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL req_latency mem_req=%b expected 1", bus.mem_req);
            for (int i = 0; i < 8 && bus.mem_req !== 1'b1; i++) @(negedge clk);
            if (bus.mem_req !== 1'b1) begin
                $display("FAIL req_never_issued mem_req=%b expected 1", bus.mem_req);
                return;
            end
        end
        checks++;
        if (bus.mem_addr !== exp_addr || bus.mem_we !== exp_we || bus.mem_be !== exp_be) begin
            errors++;
            $display("FAIL payload addr=%h we=%b be=%h expected addr=%h we=%b be=%h",
                     bus.mem_addr, bus.mem_we, bus.mem_be, exp_addr, exp_we, exp_be);
        end
        if (exp_we) begin
            checks++;
            if (bus.mem_wdata !== exp_wdata) begin
                errors++;
                $display("FAIL wdata got=%h expected %h", bus.mem_wdata, exp_wdata);
            end
        end
        for (int i = 0; i < gnt_dly; i++) begin
            checks++;
            if (bus.if_gnt !== 1'b0 || bus.dm_gnt !== 1'b0) begin
                errors++;
                $display("FAIL gnt_without_mem_gnt if_gnt=%b dm_gnt=%b expected 0 0",
                         bus.if_gnt, bus.dm_gnt);
            end
            @(negedge clk);
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_addr) begin
                errors++;
                $display("FAIL issue_hold mem_req=%b addr=%h expected 1 %h",
                         bus.mem_req, bus.mem_addr, exp_addr);
            end
        end

        bus.mem_gnt = 1'b1;
        if (mode == 1) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdata;
        end
        #1;
        checks++;
        if (bus.dm_gnt !== exp_dm || bus.if_gnt !== !exp_dm) begin
            errors++;
            $display("FAIL grant dm_gnt=%b if_gnt=%b expected %b %b",
                     bus.dm_gnt, bus.if_gnt, exp_dm, !exp_dm);
        end
        obs_log.push_back(bus.dm_gnt === 1'b1);

        @(negedge clk);
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        if (exp_dm) begin
            bus.dm_req = 1'b0;
            m_dm_pend  = 1'b0;
        end else begin
            bus.if_req = 1'b0;
            m_if_pend  = 1'b0;
        end
        checks++;
        if (bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL req_drop mem_req=%b expected 0", bus.mem_req);
        end

        for (int k = 0; k <= Timeout + 1; k++) begin
            bus.mem_rvalid = 1'b0;
            if (k == resp_k) begin
                checks++;
                if (bus.dm_rvalid !== exp_dm || bus.if_rvalid !== !exp_dm) begin
                    errors++;
                    $display("FAIL resp_valid k=%0d dm_rvalid=%b if_rvalid=%b expected %b %b",
                             k, bus.dm_rvalid, bus.if_rvalid, exp_dm, !exp_dm);
                end
                checks++;
                if (exp_dm ? (bus.dm_rdata !== exp_rdata || bus.dm_err !== exp_err)
                           : (bus.if_rdata !== exp_rdata || bus.if_err !== exp_err)) begin
                    errors++;
                    $display("FAIL resp_data dm=%h/%b if=%h/%b expected %h/%b",
                             bus.dm_rdata, bus.dm_err, bus.if_rdata, bus.if_err,
                             exp_rdata, exp_err);
                end
                return;
            end
            checks++;
            if (bus.if_rvalid !== 1'b0 || bus.dm_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL early_resp k=%0d if_rvalid=%b dm_rvalid=%b expected 0 0",
                         k, bus.if_rvalid, bus.dm_rvalid);
            end
            bus.mem_rvalid = (mode == 0 && k == rdly);
            bus.mem_rdata  = (mode == 0 && k == rdly) ? rdata : $urandom();
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== '0) begin
            errors++;
            $display("FAIL reset_mem req=%b we=%b addr=%h wdata=%h be=%h expected all 0",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be);
        end
        checks++;
        if ({bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.if_err,
             bus.dm_gnt, bus.dm_rvalid, bus.dm_rdata, bus.dm_err} !== '0) begin
            errors++;
            $display("FAIL reset_resp if=%b%b%h%b dm=%b%b%h%b expected all 0",
                     bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.if_err,
                     bus.dm_gnt, bus.dm_rvalid, bus.dm_rdata, bus.dm_err);
        end
    endtask

    task automatic test_if_fetch();
        obs_log.delete();
        raise_if(32'h100);
        run_txn(0, 0, 1, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'hDEADBEEF || bus.dm_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_hold if_rvalid=%b if_rdata=%h dm_rvalid=%b expected 0 deadbeef 0",
                     bus.if_rvalid, bus.if_rdata, bus.dm_rvalid);
        end
    endtask

    task automatic test_dm_priority();
        obs_log.delete();
        raise_dm(1'b1, 32'h200, 32'h12345678, 4'b0011);
        raise_if(32'h300);
        run_txn(1, 0, 2, $urandom());
        run_txn(0, 0, 0, 32'hCAFEF00D);
        checks++;
        if (obs_log.size() != 2 || obs_log[0] != 1'b1 || obs_log[1] != 1'b0) begin
            errors++;
            $display("FAIL priority_order n=%0d first=%b second=%b expected 2 DM(1) IF(0)",
                     obs_log.size(), obs_log[0], obs_log[1]);
        end
    endtask

    task automatic test_streak();
        bit exp_order[10];
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        do_reset();
        obs_log.delete();
        raise_dm(1'b0, 32'h1000, '0, 4'h0);
        raise_if(32'h2000);
        for (int t = 0; t < 10; t++) begin
            run_txn($urandom_range(0, 2), 0, $urandom_range(0, 3), $urandom());
            if (!m_dm_pend) raise_dm($urandom_range(0, 1), $urandom(), $urandom(), 4'($urandom()));
            if (!m_if_pend) raise_if($urandom());
        end
        for (int t = 0; t < 10; t++) begin
            checks++;
            if (t >= obs_log.size() || obs_log[t] != exp_order[t]) begin
                errors++;
                $display("FAIL streak_order idx=%0d got_dm=%b expected_dm=%b",
                         t, (t < obs_log.size()) ? obs_log[t] : 1'bx, exp_order[t]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        raise_dm(1'b0, 32'h40, '0, 4'h0);
        run_txn(0, 0, 0, 32'h0BADF00D);
        raise_dm(1'b0, 32'h44, '0, 4'h0);
        run_txn(0, 2, 0, '0);
        @(negedge clk);
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h77777777;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.dm_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0 || bus.mem_req !== 1'b0
                || bus.dm_rdata !== 32'h0) begin
                errors++;
                $display("FAIL late_rvalid cyc=%0d dm_rvalid=%b if_rvalid=%b req=%b rdata=%h expected 0 0 0 0",
                         i, bus.dm_rvalid, bus.if_rvalid, bus.mem_req, bus.dm_rdata);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        raise_dm(1'b0, 32'h80, '0, 4'h0);
        run_txn(0, 1, 0, 32'hA5A5A5A5);
        // Arbitrating right away proves the arbiter went back to IDLE.
        raise_if(32'h84);
        run_txn(0, 0, 0, 32'h5A5A5A5A);
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        raise_dm(1'b0, 32'h500, '0, 4'h0);
        run_txn(0, 0, 0, 32'h11223344);
        raise_dm(1'b0, 32'h504, '0, 4'h0);
        @(negedge clk);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        bus.dm_req  = 1'b0;
        m_dm_pend   = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn         = 1'b1;
        m_streak       = 0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h99999999;
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be,
             bus.dm_rvalid, bus.dm_rdata, bus.dm_err, bus.if_rvalid, bus.if_rdata,
             bus.if_err} !== '0) begin
            errors++;
            $display("FAIL reset_wait req=%b addr=%h be=%h dm=%b/%h/%b if=%b/%h/%b expected all 0",
                     bus.mem_req, bus.mem_addr, bus.mem_be, bus.dm_rvalid, bus.dm_rdata,
                     bus.dm_err, bus.if_rvalid, bus.if_rdata, bus.if_err);
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        checks++;
        if (bus.dm_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL stale_rvalid dm_rvalid=%b if_rvalid=%b expected 0 0",
                     bus.dm_rvalid, bus.if_rvalid);
        end
        raise_if(32'h600);
        run_txn(0, 0, 0, 32'h600D600D);
    endtask

    task automatic test_random();
        int mode;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            if (!m_if_pend && $urandom_range(0, 1) == 1) raise_if($urandom());
            if (!m_dm_pend && $urandom_range(0, 2) != 0) begin
                raise_dm($urandom_range(0, 1), $urandom(), $urandom(), 4'($urandom()));
            end
            if (!m_if_pend && !m_dm_pend) raise_if($urandom());
            mode = $urandom_range(0, 9);
            if (mode == 0) run_txn($urandom_range(0, 3), 2, 0, $urandom());
            else if (mode == 1) run_txn($urandom_range(0, 3), 1, 0, $urandom());
            else run_txn($urandom_range(0, 3), 0, $urandom_range(0, Timeout - 1), $urandom());
        end
    endtask

    initial begin
        test_reset();
        test_if_fetch();
        test_dm_priority();
        test_streak();
        test_timeout();
        test_same_cycle();
        test_reset_in_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
